// File: rtl/interp_lerp_multi.sv
// Multi-channel linear interpolator: val_c = min_c + (max_c - min_c) * g, g clamped to [0,1].
// Optional build macro INTERP_ROUND_EN: round half away from zero instead of truncating toward zero.
module interp_lerp_multi #(
    parameter int NCH   = 3,
    parameter int DW    = 16,
    parameter int VFRAC = 7,
    parameter int GFRAC = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH*DW-1:0]   min_val,
    input  logic [NCH*DW-1:0]   max_val,
    input  logic [DW-1:0]       gradient,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NCH*DW-1:0]   val,
    output logic                busy
);

    localparam int PW = 2 * DW + 1;
    localparam logic [DW-1:0] G_ONE = DW'(1) << GFRAC;

    typedef enum logic [1:0] {IDLE, MUL, SHIFT, OUT} state_t;

    state_t              state_q, state_d;
    logic [NCH*DW-1:0]   min_q, max_q;
    logic [DW-1:0]       grad_q;
    logic [PW-1:0]       prod_q [NCH];
    logic [PW-1:0]       prod_d [NCH];
    logic [NCH*DW-1:0]   val_q, val_d;
    logic                accept;
    logic                g_neg, g_ge_one;

    // Fractional widths must leave at least a sign bit in DW.
    if (GFRAC < 1 || GFRAC >= DW || VFRAC >= DW) begin : g_bad_params
        $error("interp_lerp_multi: GFRAC/VFRAC out of range for DW");
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign val       = val_q;
    assign accept    = in_valid && in_ready;

    assign g_neg    = grad_q[DW-1];
    assign g_ge_one = !g_neg && (grad_q >= G_ONE);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DW-1:0]        min_c, max_c, res_c;
            logic signed [DW:0]   diff;
            logic signed [PW-1:0] prod_full;
            logic [PW-1:0]        mag, q, shifted;
            logic                 prod_neg;
            logic                 unused_hi;

            assign min_c = min_q[gi*DW +: DW];
            assign max_c = max_q[gi*DW +: DW];

            assign diff      = $signed({max_c[DW-1], max_c}) - $signed({min_c[DW-1], min_c});
            assign prod_full = $signed({{DW{diff[DW]}}, diff})
                             * $signed({{(DW+1){grad_q[DW-1]}}, grad_q});
            assign prod_d[gi] = prod_full;

            // Shift the magnitude so negative products truncate toward zero.
            assign prod_neg = prod_q[gi][PW-1];
`ifdef INTERP_ROUND_EN
            localparam logic [PW-1:0] ROUND_HALF = PW'(1) << (GFRAC - 1);
            assign mag = (prod_neg ? -prod_q[gi] : prod_q[gi]) + ROUND_HALF;
`else
            assign mag = prod_neg ? -prod_q[gi] : prod_q[gi];
`endif
            assign q       = mag >> GFRAC;
            assign shifted = prod_neg ? -q : q;
            assign res_c   = min_c + shifted[DW-1:0];

            assign val_d[gi*DW +: DW] = g_neg ? min_c : (g_ge_one ? max_c : res_c);

            assign unused_hi = ^shifted[PW-1:DW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL;
            MUL:     state_d = SHIFT;
            SHIFT:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q  <= '0;
            max_q  <= '0;
            grad_q <= '0;
            val_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                prod_q[c] <= '0;
            end
        end else begin
            if (accept) begin
                min_q  <= min_val;
                max_q  <= max_val;
                grad_q <= gradient;
            end
            if (state_q == MUL) begin
                for (int c = 0; c < NCH; c++) begin
                    prod_q[c] <= prod_d[c];
                end
            end
            if (state_q == SHIFT) begin
                val_q <= val_d;
            end
        end
    end

endmodule
